// File: rtl/ghost_chase_ctrl_pkg.sv
// Shared grid geometry, start positions, FSM states and candidate helpers
// for the ghost chase controller.
package ghost_chase_ctrl_pkg;

    localparam int unsigned W      = 64;
    localparam int unsigned H      = 32;
    localparam int unsigned X_W    = $clog2(W);
    localparam int unsigned Y_W    = $clog2(H);
    localparam int unsigned ADDR_W = X_W + Y_W;

    localparam logic [7:0] MAP_MAX = 8'hFF;

    // Packed so that a position is directly the {y,x} map address.
    typedef struct packed {
        logic [Y_W-1:0] y;
        logic [X_W-1:0] x;
    } pos_t;

    localparam pos_t G1_START = '{y: 5'd13, x: 6'd16};
    localparam pos_t G2_START = '{y: 5'd13, x: 6'd23};

    typedef enum logic [3:0] {
        S_INIT, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5, S_RD6, S_RD7, S_RD8,
        S_DECIDE, S_WAIT
    } state_t;

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    function automatic pos_t step(input pos_t p, input dir_t d);
        pos_t r;
        r = p;
        case (d)
            DIR_UP:    r.y = p.y - Y_W'(1);
            DIR_DOWN:  r.y = p.y + Y_W'(1);
            DIR_LEFT:  r.x = p.x - X_W'(1);
            default:   r.x = p.x + X_W'(1);
        endcase
        return r;
    endfunction

    function automatic logic [7:0] manhattan(input pos_t a, input pos_t b);
        logic [X_W-1:0] dx;
        logic [Y_W-1:0] dy;
        dx = (a.x > b.x) ? a.x - b.x : b.x - a.x;
        dy = (a.y > b.y) ? a.y - b.y : b.y - a.y;
        return {2'b00, dx} + {3'b000, dy};
    endfunction

    // Strict less-than keeps the earliest direction on ties.
    function automatic dir_t pick(input logic [3:0][7:0] v);
        dir_t       best;
        logic [7:0] bv;
        best = DIR_UP;
        bv   = v[0];
        if (v[1] < bv) begin best = DIR_DOWN;  bv = v[1]; end
        if (v[2] < bv) begin best = DIR_LEFT;  bv = v[2]; end
        if (v[3] < bv) begin best = DIR_RIGHT; end
        return best;
    endfunction

endpackage

// File: rtl/ghost_chase_ctrl_counter.sv
// Free-running wrap counter pacing the ghost decisions (0..MAX-1).
module counter #(
    parameter int unsigned MAX = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic [$clog2(MAX)-1:0] count
);

    localparam int unsigned CNT_W = $clog2(MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (count == CNT_W'(MAX - 1)) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ghost_chase_ctrl_ram.sv
// Proximity map: endless sweep writing Manhattan distance to Pac-Man,
// synchronous read port with reverse-move penalty, and the ready flag.
module ghost_RAM_ctrl
    import ghost_chase_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [X_W-1:0] pacman_x,
    input  logic [Y_W-1:0] pacman_y,
    input  pos_t           rd_addr,
    input  pos_t           prev1,
    input  pos_t           prev2,
    output logic [7:0]     rd_data,
    output logic           ready
);

    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] waddr;
    pos_t              sweep_pac;
    pos_t              pac_eff;
    pos_t              rd_addr_q;
    logic [7:0]        rd_raw;

    // Cell 0 uses the live Pac-Man position, which is latched for the rest of the sweep.
    assign pac_eff = (waddr == '0) ? pos_t'({pacman_y, pacman_x}) : sweep_pac;

    always_ff @(posedge clk) begin
        if (reset) begin
            waddr     <= '0;
            sweep_pac <= '0;
            ready     <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            waddr     <= waddr + ADDR_W'(1);
            rd_addr_q <= rd_addr;
            if (waddr == '0) sweep_pac <= pac_eff;
            if (waddr == '1) ready <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        mem[waddr] <= manhattan(pos_t'(waddr), pac_eff);
        rd_raw     <= mem[rd_addr];
    end

    assign rd_data = (rd_addr_q == prev1 || rd_addr_q == prev2) ? MAP_MAX : rd_raw;

endmodule

// File: rtl/ghost_chase_ctrl.sv
// Ghost chase controller top: scan FSM over the eight neighbour reads,
// min-distance decision, and committed/previous/next ghost positions.
module ghost_chase_ctrl
    import ghost_chase_ctrl_pkg::*;
#(
    parameter int unsigned MAX = 5
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    input  logic [X_W-1:0] curr_pacman_x,
    input  logic [Y_W-1:0] curr_pacman_y,
    input  logic [1:0]     collision_type,
    input  logic [32:0]    pill_counter,
    input  logic           wrdone,
    output logic [X_W-1:0] next_ghost1_x,
    output logic [Y_W-1:0] next_ghost1_y,
    output logic [X_W-1:0] next_ghost2_x,
    output logic [Y_W-1:0] next_ghost2_y
);

    state_t                  state;
    pos_t                    curr1, curr2, prev1, prev2, nxt1, nxt2, snap1, snap2;
    pos_t                    rd_addr, base;
    logic [2:0]              cap_idx, rd_sel;
    logic [7:0][7:0]         vals;
    logic [7:0]              rd_data;
    logic                    ready;
    logic [$clog2(MAX)-1:0] tick;
    logic                    unused_inputs;

    assign unused_inputs = ^{collision_type, pill_counter};

    counter #(.MAX(MAX)) u_tick (
        .clk   (CLOCK_50),
        .reset (reset),
        .count (tick)
    );

    ghost_RAM_ctrl u_map (
        .clk      (CLOCK_50),
        .reset    (reset),
        .pacman_x (curr_pacman_x),
        .pacman_y (curr_pacman_y),
        .rd_addr  (rd_addr),
        .prev1    (prev1),
        .prev2    (prev2),
        .rd_data  (rd_data),
        .ready    (ready)
    );

    // Read k = {ghost, dir}; INIT issues read 0 from live curr, before the snapshot lands.
    always_comb begin
        rd_sel  = cap_idx + 3'd1;
        base    = rd_sel[2] ? snap2 : snap1;
        rd_addr = step(base, dir_t'(rd_sel[1:0]));
        if (state == S_INIT) rd_addr = step(curr1, DIR_UP);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= S_INIT;
            cap_idx <= '0;
            vals    <= '0;
            curr1   <= G1_START;
            prev1   <= G1_START;
            nxt1    <= G1_START;
            snap1   <= G1_START;
            curr2   <= G2_START;
            prev2   <= G2_START;
            nxt2    <= G2_START;
            snap2   <= G2_START;
        end else begin
            if (wrdone) begin
                curr1 <= nxt1;
                curr2 <= nxt2;
                prev1 <= curr1;
                prev2 <= curr2;
            end
            case (state)
                S_INIT: begin
                    cap_idx <= '0;
                    if (ready) begin
                        snap1 <= curr1;
                        snap2 <= curr2;
                        state <= S_RD1;
                    end
                end
                S_RD1, S_RD2, S_RD3, S_RD4, S_RD5, S_RD6, S_RD7, S_RD8: begin
                    vals[cap_idx] <= rd_data;
                    cap_idx       <= cap_idx + 3'd1;
                    state         <= (state == S_RD8) ? S_DECIDE : state_t'(state + 4'd1);
                end
                S_DECIDE: begin
                    nxt1  <= step(snap1, pick(vals[3:0]));
                    nxt2  <= step(snap2, pick(vals[7:4]));
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (tick == '0) state <= S_INIT;
                end
                default: state <= S_INIT;
            endcase
        end
    end

    assign next_ghost1_x = nxt1.x;
    assign next_ghost1_y = nxt1.y;
    assign next_ghost2_x = nxt2.x;
    assign next_ghost2_y = nxt2.y;

endmodule

// File: tb/tb_ghost_chase_ctrl.sv
// Scoreboard bench for ghost_chase_ctrl: a distance/penalty model predicts each
// decision; a monitor pops and compares whenever a new choice is registered.
module tb_ghost_chase_ctrl;
    import ghost_chase_ctrl_pkg::*;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  curr_pacman_x = '0;
    logic [4:0]  curr_pacman_y = '0;
    logic [1:0]  collision_type = '0;
    logic [32:0] pill_counter = '0;
    logic        wrdone = 1'b0;
    logic [5:0]  next_ghost1_x, next_ghost2_x;
    logic [4:0]  next_ghost1_y, next_ghost2_y;

    ghost_chase_ctrl #(.MAX(5)) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .curr_pacman_x  (curr_pacman_x),
        .curr_pacman_y  (curr_pacman_y),
        .collision_type (collision_type),
        .pill_counter   (pill_counter),
        .wrdone         (wrdone),
        .next_ghost1_x  (next_ghost1_x),
        .next_ghost1_y  (next_ghost1_y),
        .next_ghost2_x  (next_ghost2_x),
        .next_ghost2_y  (next_ghost2_y)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int x1;
        int y1;
        int x2;
        int y2;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   e;
    int     checks = 0;
    int     errors = 0;
    int     dec_count = 0;
    int     cyc = 0;
    int     settle_cyc = 0;
    state_t mon_prev = S_INIT;

    int m_cx[2], m_cy[2], m_px[2], m_py[2], m_nx[2], m_ny[2];
    int pac_x, pac_y;

    always @(posedge CLOCK_50) cyc++;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int cell_val(input int x, input int y);
        if ((x == m_px[0] && y == m_py[0]) || (x == m_px[1] && y == m_py[1])) return 255;
        return iabs(x - pac_x) + iabs(y - pac_y);
    endfunction

    function automatic void choose(input int g);
        int bv, v, cx, cy;
        bv = -1;
        for (int d = 0; d < 4; d++) begin
            cx = m_cx[g];
            cy = m_cy[g];
            case (d)
                0:       cy = (cy + 31) % 32;
                1:       cy = (cy + 1) % 32;
                2:       cx = (cx + 63) % 64;
                default: cx = (cx + 1) % 64;
            endcase
            v = cell_val(cx, cy);
            if (bv < 0 || v < bv) begin
                bv = v;
                m_nx[g] = cx;
                m_ny[g] = cy;
            end
        end
    endfunction

    function automatic void predict(input bit push);
        choose(0);
        choose(1);
        if (push) exp_q.push_back('{m_nx[0], m_ny[0], m_nx[1], m_ny[1]});
    endfunction

    function automatic void commit();
        for (int g = 0; g < 2; g++) begin
            m_px[g] = m_cx[g];
            m_py[g] = m_cy[g];
            m_cx[g] = m_nx[g];
            m_cy[g] = m_ny[g];
        end
    endfunction

    function automatic void model_reset();
        m_cx[0] = 16; m_cy[0] = 13; m_cx[1] = 23; m_cy[1] = 13;
        for (int g = 0; g < 2; g++) begin
            m_px[g] = m_cx[g]; m_py[g] = m_cy[g];
            m_nx[g] = m_cx[g]; m_ny[g] = m_cy[g];
        end
    endfunction

    task automatic set_pac(input int x, input int y);
        pac_x = x;
        pac_y = y;
        curr_pacman_x = 6'(x);
        curr_pacman_y = 5'(y);
    endtask

    task automatic check_start(input string tag);
        check({tag, "_g1_x"}, int'(next_ghost1_x), 16);
        check({tag, "_g1_y"}, int'(next_ghost1_y), 13);
        check({tag, "_g2_x"}, int'(next_ghost2_x), 23);
        check({tag, "_g2_y"}, int'(next_ghost2_y), 13);
    endtask

    task automatic wait_decision(input int limit);
        int start;
        bit ok;
        start = dec_count;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge CLOCK_50);
            #2;
            if (dec_count != start) begin
                ok = 1'b1;
                break;
            end
        end
        check("decision_arrived", int'(ok), 1);
    endtask

    // Monitor: the edge ending DECIDE registers a new choice.
    always @(posedge CLOCK_50) begin
        #1;
        if (!reset && mon_prev == S_DECIDE) begin
            dec_count++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("next_g1_x", int'(next_ghost1_x), e.x1);
                check("next_g1_y", int'(next_ghost1_y), e.y1);
                check("next_g2_x", int'(next_ghost2_x), e.x2);
                check("next_g2_y", int'(next_ghost2_y), e.y2);
            end
        end
        mon_prev = dut.state;
    end

    initial begin
        int  r, start, px, py;
        bit  last_pred;

        set_pac(20, 20);
        model_reset();
        reset = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_start("reset");
        #1;
        reset = 1'b0;
        settle_cyc = cyc;

        exp_q.push_back('{16, 14, 23, 14});
        predict(1'b0);

        // Last edge before ready can be seen: nothing decided yet.
        repeat (2048) @(posedge CLOCK_50);
        #1;
        check_start("pre_ready");
        check("early_decisions", dec_count, 0);
        #1;
        wait_decision(40);

        wrdone = 1'b1;
        commit();
        @(posedge CLOCK_50);
        #2;
        wrdone = 1'b0;
        exp_q.push_back('{16, 15, 23, 15});
        predict(1'b0);
        wait_decision(100);

        last_pred = 1'b1;
        for (int unsigned it = 0; it < 1200; it++) begin
            r = $urandom_range(0, 29);
            if (last_pred && r < 18) begin
                wrdone = 1'b1;
                commit();
                @(posedge CLOCK_50);
                #2;
                wrdone = 1'b0;
            end else if (last_pred && r == 18) begin
                case ($urandom_range(0, 2))
                    0:       px = 0;
                    1:       px = 63;
                    default: px = $urandom_range(0, 63);
                endcase
                case ($urandom_range(0, 2))
                    0:       py = 0;
                    1:       py = 31;
                    default: py = $urandom_range(0, 31);
                endcase
                set_pac(px, py);
                settle_cyc = cyc + 4200;
            end
            if (cyc >= settle_cyc) begin
                predict(1'b1);
                last_pred = 1'b1;
            end else begin
                last_pred = 1'b0;
            end
            wait_decision(100);
        end

        // Abort mid-scan.
        repeat (4) @(posedge CLOCK_50);
        #2;
        reset = 1'b1;
        exp_q.delete();
        model_reset();
        @(posedge CLOCK_50);
        #1;
        check_start("mid_reset");
        #1;
        @(posedge CLOCK_50);
        #2;
        reset = 1'b0;
        start = dec_count;
        repeat (2040) @(posedge CLOCK_50);
        #1;
        check("no_decision_before_ready", dec_count - start, 0);
        check_start("post_reset_hold");
        #1;
        predict(1'b1);
        wait_decision(60);

        repeat (3) @(posedge CLOCK_50);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
